spectrum_capture: RTL and testbench

Downstream consumer of the FFT block's frequency-sample stream. Captures one contiguous frame of the 512 non-redundant power bins (0–511) into a ping-pong pair of 512×8 banks. Hands the completed bank to the display side during display blanking, so the display always scans a complete, stable spectrum. Optionally reports the strongest non-DC bin of each frame.

---
 rtl/spectrum_capture_if.sv | 42 ++++
 rtl/spectrum_capture.sv | 194 +++++++++++++++++++
 tb/tb_spectrum_capture.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_capture_if.sv
// spectrum_capture_if
// Groups the frequency-sample stream, the display-side controls and the
// capture status outputs of spectrum_capture into one bundle.
//   master : the environment (FFT stream source + display controller)
//   slave  : the spectrum_capture block
// Signals:
//   flgFreqSampleValid/addrFreq/byteFreqSample : sample stream, one sample per
//     cycle when valid; there is no ready, the capture side always accepts or
//     ignores a sample in the cycle it is offered.
//   flgFreeze, flgDispBlank, addrDisp           : display-side controls
//   byteDisp, flgFrameReady, flgFrameErr,
//   cntFramesDropped, peakBin, peakVal          : capture status / read data
//   dbg_state                                   : capture FSM state (debug)
interface spectrum_capture_if;
  logic       flgFreqSampleValid;
  logic [9:0] addrFreq;
  logic [7:0] byteFreqSample;
  logic       flgFreeze;
  logic       flgDispBlank;
  logic [8:0] addrDisp;
  logic [7:0] byteDisp;
  logic       flgFrameReady;
  logic       flgFrameErr;
  logic [7:0] cntFramesDropped;
  logic [8:0] peakBin;
  logic [7:0] peakVal;
  logic [1:0] dbg_state;

  modport master (
    output flgFreqSampleValid, addrFreq, byteFreqSample,
    output flgFreeze, flgDispBlank, addrDisp,
    input  byteDisp, flgFrameReady, flgFrameErr, cntFramesDropped,
    input  peakBin, peakVal, dbg_state
  );

  modport slave (
    input  flgFreqSampleValid, addrFreq, byteFreqSample,
    input  flgFreeze, flgDispBlank, addrDisp,
    output byteDisp, flgFrameReady, flgFrameErr, cntFramesDropped,
    output peakBin, peakVal, dbg_state
  );
endinterface

// File: rtl/spectrum_capture.sv
// spectrum_capture
// Captures one contiguous frame of the 512 non-redundant FFT power bins into
// one half of a ping-pong pair of 512x8 banks and hands the finished bank to
// the display during blanking, so the display always scans a complete frame.
// Ports:
//   ckFreq   : frequency-domain clock (same clock as the FFT sample stream)
//   aresetn  : asynchronous active-low reset
//   bus      : spectrum_capture_if.slave (sample stream, display controls,
//              registered display read data, pulses, dropped-frame counter,
//              peak report, FSM debug state)
// Optional feature: define SPECTRUM_PEAK_DETECT_EN to track the strongest
// non-DC bin of each frame (peakBin/peakVal); otherwise both outputs are 0.
module spectrum_capture (
  input  logic               ckFreq,
  input  logic               aresetn,
  spectrum_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_CAPTURE   = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] cnt_exp_q, cnt_exp_d;
  logic       bank_wr_q, bank_wr_d;
  logic       bank_valid_q, bank_valid_d;
  logic       frame_ready_q, frame_ready_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] dropped_q, dropped_d;
  logic [7:0] byte_disp_q, byte_disp_d;

  logic       wr_en;
  logic [8:0] wr_addr;

  // Bank contents are never reset; flgBankValid masks reads until a swap.
  logic [7:0] bank0_mem [0:511];
  logic [7:0] bank1_mem [0:511];

`ifdef SPECTRUM_PEAK_DETECT_EN
  logic [7:0] run_val_q, run_val_d;
  logic [8:0] run_bin_q, run_bin_d;
  logic [7:0] peak_val_q, peak_val_d;
  logic [8:0] peak_bin_q, peak_bin_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_exp_d     = cnt_exp_q;
    bank_wr_d     = bank_wr_q;
    bank_valid_d  = bank_valid_q;
    dropped_d     = dropped_q;
    frame_ready_d = 1'b0;
    frame_err_d   = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = bus.addrFreq[8:0];
`ifdef SPECTRUM_PEAK_DETECT_EN
    run_val_d     = run_val_q;
    run_bin_d     = run_bin_q;
    peak_val_d    = peak_val_q;
    peak_bin_d    = peak_bin_q;
`endif

    // bank_wr_q selects the capture bank, so the display bank is the other.
    // The read uses the pre-swap selection on the swap edge, so a swap is
    // visible to reads issued from the following cycle onward.
    if (bank_valid_q) begin
      byte_disp_d = bank_wr_q ? bank0_mem[bus.addrDisp] : bank1_mem[bus.addrDisp];
    end else begin
      byte_disp_d = 8'd0;
    end

    case (state_q)
      ST_HUNT: begin
        if (bus.flgFreqSampleValid && (bus.addrFreq == 10'd0) && !bus.flgFreeze) begin
          wr_en     = 1'b1;
          cnt_exp_d = 9'd1;
          state_d   = ST_CAPTURE;
`ifdef SPECTRUM_PEAK_DETECT_EN
          // DC bin is excluded from the running max.
          run_val_d = 8'd0;
          run_bin_d = 9'd0;
`endif
        end
      end

      ST_CAPTURE: begin
        if (bus.flgFreqSampleValid) begin
          // Zero-extending cnt_exp makes any address >= 512 a mismatch.
          if (bus.addrFreq == {1'b0, cnt_exp_q}) begin
            wr_en     = 1'b1;
            cnt_exp_d = cnt_exp_q + 9'd1;
            if (cnt_exp_q == 9'd511) begin
              state_d = ST_WAIT_SWAP;
            end
`ifdef SPECTRUM_PEAK_DETECT_EN
            // Strict greater-than keeps the lowest bin on ties.
            if (bus.byteFreqSample > run_val_q) begin
              run_val_d = bus.byteFreqSample;
              run_bin_d = cnt_exp_q;
            end
`endif
          end else begin
            // A mismatching bin 0 does not restart capture in this cycle.
            frame_err_d = 1'b1;
            state_d     = ST_HUNT;
          end
        end
      end

      ST_WAIT_SWAP: begin
        // Each frame start seen while waiting is a frame we had to skip.
        if (bus.flgFreqSampleValid && (bus.addrFreq == 10'd0) && (dropped_q != 8'hFF)) begin
          dropped_d = dropped_q + 8'd1;
        end
        if (bus.flgDispBlank) begin
          bank_wr_d     = ~bank_wr_q;
          bank_valid_d  = 1'b1;
          frame_ready_d = 1'b1;
          state_d       = ST_HUNT;
`ifdef SPECTRUM_PEAK_DETECT_EN
          peak_val_d    = run_val_q;
          peak_bin_d    = run_bin_q;
`endif
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge ckFreq or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_HUNT;
      cnt_exp_q     <= 9'd0;
      bank_wr_q     <= 1'b0;
      bank_valid_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_err_q   <= 1'b0;
      dropped_q     <= 8'd0;
      byte_disp_q   <= 8'd0;
`ifdef SPECTRUM_PEAK_DETECT_EN
      run_val_q     <= 8'd0;
      run_bin_q     <= 9'd0;
      peak_val_q    <= 8'd0;
      peak_bin_q    <= 9'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_exp_q     <= cnt_exp_d;
      bank_wr_q     <= bank_wr_d;
      bank_valid_q  <= bank_valid_d;
      frame_ready_q <= frame_ready_d;
      frame_err_q   <= frame_err_d;
      dropped_q     <= dropped_d;
      byte_disp_q   <= byte_disp_d;
`ifdef SPECTRUM_PEAK_DETECT_EN
      run_val_q     <= run_val_d;
      run_bin_q     <= run_bin_d;
      peak_val_q    <= peak_val_d;
      peak_bin_q    <= peak_bin_d;
`endif
    end
  end

  // Capture write lands on the same edge that samples the valid input.
  always_ff @(posedge ckFreq) begin
    if (wr_en) begin
      if (bank_wr_q) begin
        bank1_mem[wr_addr] <= bus.byteFreqSample;
      end else begin
        bank0_mem[wr_addr] <= bus.byteFreqSample;
      end
    end
  end

  assign bus.byteDisp         = byte_disp_q;
  assign bus.flgFrameReady    = frame_ready_q;
  assign bus.flgFrameErr      = frame_err_q;
  assign bus.cntFramesDropped = dropped_q;
  assign bus.dbg_state        = state_q;

`ifdef SPECTRUM_PEAK_DETECT_EN
  assign bus.peakBin = peak_bin_q;
  assign bus.peakVal = peak_val_q;
`else
  assign bus.peakBin = 9'd0;
  assign bus.peakVal = 8'd0;
`endif

endmodule

// File: tb/tb_spectrum_capture.sv
// tb_spectrum_capture
// Directed bench for spectrum_capture: reset state, basic capture and swap
// timing, discontinuity handling, deferred swap with dropped-frame counting,
// peak report, freeze, and reset in the middle of a capture.
module tb_spectrum_capture;

  logic ckFreq  = 1'b0;
  logic aresetn = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int ready_seen  = 0;
  int err_seen    = 0;
  int r0, e0;

  logic [7:0] exp_q[$];

  spectrum_capture_if bus ();

  spectrum_capture dut (
    .ckFreq  (ckFreq),
    .aresetn (aresetn),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  always #5 ckFreq = ~ckFreq;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge ckFreq) begin
    if (bus.flgFrameReady) ready_seen++;
    if (bus.flgFrameErr)   err_seen++;
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] pat(input int a, input logic [7:0] k);
    logic [31:0] t;
    t = a;
    return t[7:0] ^ k;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] a, input logic [7:0] d);
    @(negedge ckFreq);
    bus.flgFreqSampleValid = v;
    bus.addrFreq           = a;
    bus.byteFreqSample     = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 10'd0, 8'd0);
  endtask

  task automatic feed(input int lo, input int hi, input logic [7:0] k);
    for (int a = lo; a <= hi; a++) drive(1'b1, 10'(a), pat(a, k));
  endtask

  task automatic feed_peak();
    logic [7:0] d;
    for (int a = 0; a <= 511; a++) begin
      if (a == 0) d = 8'd255;
      else if (a == 77 || a == 200) d = 8'd180;
      else d = 8'd10;
      drive(1'b1, 10'(a), d);
    end
  endtask

  task automatic read_check(input logic [8:0] addr, input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    @(negedge ckFreq);
    bus.flgFreqSampleValid = 1'b0;
    bus.addrDisp           = addr;
    @(negedge ckFreq);
    check(tag, 16'(bus.byteDisp), 16'(exp_q.pop_front()));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.flgFreqSampleValid = 1'b0;
    bus.addrFreq           = 10'd0;
    bus.byteFreqSample     = 8'd0;
    bus.flgFreeze          = 1'b0;
    bus.flgDispBlank       = 1'b0;
    bus.addrDisp           = 9'd5;
    aresetn                = 1'b0;
    repeat (3) @(negedge ckFreq);
    aresetn = 1'b1;
    idle(3);

    // Reset state
    check("rst_byteDisp", 16'(bus.byteDisp), 16'd0);
    check("rst_dropped", 16'(bus.cntFramesDropped), 16'd0);
    check("rst_ready", 16'(bus.flgFrameReady), 16'd0);
    check("rst_err", 16'(bus.flgFrameErr), 16'd0);
    check("rst_peakBin", 16'(bus.peakBin), 16'd0);
    check("rst_peakVal", 16'(bus.peakVal), 16'd0);
    check("rst_no_pulses", 16'(ready_seen + err_seen), 16'd0);

    // Basic capture: swap one cycle after bin 511, pulse the cycle after that
    bus.flgDispBlank = 1'b1;
    r0 = ready_seen;
    feed(0, 511, 8'h00);
    feed(512, 512, 8'h00);
    check("basic_ready_early", 16'(bus.flgFrameReady), 16'd0);
    feed(513, 513, 8'h00);
    check("basic_ready_pulse", 16'(bus.flgFrameReady), 16'd1);
    feed(514, 1023, 8'h00);
    idle(2);
    check("basic_ready_count", 16'(ready_seen - r0), 16'd1);
    read_check(9'd300, 8'd44, "basic_rd300");
    read_check(9'd0, 8'd0, "basic_rd0");
    read_check(9'd511, 8'd255, "basic_rd511");

    // Discontinuity at bin 100
    r0 = ready_seen;
    e0 = err_seen;
    feed(0, 99, 8'h33);
    feed(101, 101, 8'h33);
    idle(1);
    check("disc_err_pulse", 16'(bus.flgFrameErr), 16'd1);
    idle(2);
    check("disc_err_count", 16'(err_seen - e0), 16'd1);
    check("disc_no_ready", 16'(ready_seen - r0), 16'd0);
    read_check(9'd300, 8'd44, "disc_disp_kept");
    r0 = ready_seen;
    feed(0, 1023, 8'h5A);
    idle(2);
    check("clean_ready_count", 16'(ready_seen - r0), 16'd1);
    read_check(9'd300, 8'h76, "clean_rd300");
    read_check(9'd50, 8'h68, "clean_rd50");

    // Deferred swap: one captured frame, three skipped
    bus.flgDispBlank = 1'b0;
    r0 = ready_seen;
    for (int k = 1; k <= 4; k++) feed(0, 1023, 8'(k));
    idle(2);
    check("defer_dropped", 16'(bus.cntFramesDropped), 16'd3);
    check("defer_no_ready", 16'(ready_seen - r0), 16'd0);
    read_check(9'd300, 8'h76, "defer_disp_kept");
    bus.flgDispBlank = 1'b1;
    idle(3);
    check("defer_ready_count", 16'(ready_seen - r0), 16'd1);
    read_check(9'd300, 8'd45, "defer_rd300");
    read_check(9'd7, 8'd6, "defer_rd7");
    check("defer_dropped_hold", 16'(bus.cntFramesDropped), 16'd3);

    // Peak report: DC excluded, tie resolved to the lower bin
    r0 = ready_seen;
    feed_peak();
    idle(3);
    check("peak_ready_count", 16'(ready_seen - r0), 16'd1);
`ifdef SPECTRUM_PEAK_DETECT_EN
    check("peak_bin", 16'(bus.peakBin), 16'd77);
    check("peak_val", 16'(bus.peakVal), 16'd180);
`else
    check("peak_bin", 16'(bus.peakBin), 16'd0);
    check("peak_val", 16'(bus.peakVal), 16'd0);
`endif
    read_check(9'd0, 8'd255, "peak_rd0");
    read_check(9'd77, 8'd180, "peak_rd77");
    read_check(9'd200, 8'd180, "peak_rd200");

    // Freeze: no capture starts, display keeps its frame
    bus.flgFreeze = 1'b1;
    r0 = ready_seen;
    feed(0, 1023, 8'h77);
    idle(2);
    check("freeze_no_ready", 16'(ready_seen - r0), 16'd0);
    read_check(9'd200, 8'd180, "freeze_disp_kept");
    bus.flgFreeze = 1'b0;

    // Reset in the middle of a capture
    feed(0, 250, 8'h11);
    check("prerst_disp", 16'(bus.byteDisp), 16'd180);
    #1 aresetn = 1'b0;
    #1;
    check("midrst_byteDisp", 16'(bus.byteDisp), 16'd0);
    check("midrst_dropped", 16'(bus.cntFramesDropped), 16'd0);
    check("midrst_peakVal", 16'(bus.peakVal), 16'd0);
    bus.flgFreqSampleValid = 1'b0;
    @(negedge ckFreq);
    @(negedge ckFreq);
    aresetn = 1'b1;
    idle(2);
    read_check(9'd200, 8'd0, "postrst_rd200");
    read_check(9'd300, 8'd0, "postrst_rd300");
    r0 = ready_seen;
    feed(0, 1023, 8'h22);
    idle(2);
    check("postrst_ready_count", 16'(ready_seen - r0), 16'd1);
    read_check(9'd300, 8'd14, "postrst_rd300_new");
    read_check(9'd255, 8'hDD, "postrst_rd255_new");
    check("postrst_dropped", 16'(bus.cntFramesDropped), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
